// File: rtl/button_cntr_multi.sv
// N-channel push-button front end.
// Each channel has an input synchronizer, a sampled debounce filter, registered
// press/release pulses, a long-press pulse and optional auto-repeat pulses.
// One prescaler produces the sample tick for every channel.
module button_cntr_multi #(
    parameter int N_BTN        = 4,
    parameter int SAMPLE_DIV   = 32768,
    parameter int STABLE_CNT   = 3,
    parameter int LONG_TICKS   = 100,
    parameter int REPEAT_TICKS = 20,
    parameter bit ACTIVE_LOW   = 1'b0
) (
    input  logic             clk,
    input  logic             reset_p,
    input  logic [N_BTN-1:0] btn,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pedge,
    output logic [N_BTN-1:0] btn_nedge,
    output logic [N_BTN-1:0] btn_long,
    output logic [N_BTN-1:0] btn_rep,
    output logic             sample_tick
);

    localparam int PW = $clog2(SAMPLE_DIV);
    localparam int SW = $clog2(STABLE_CNT + 1);
    localparam int HW = $clog2(LONG_TICKS + REPEAT_TICKS + 1);

    localparam logic [PW-1:0] DIV_LAST = PW'(SAMPLE_DIV - 1);
    localparam logic [PW-1:0] DIV_PRE  = PW'(SAMPLE_DIV - 2);
    localparam logic [SW-1:0] STABLE_V = SW'(STABLE_CNT);
    localparam logic [HW-1:0] LONG_V   = HW'(LONG_TICKS);
    localparam logic [HW-1:0] TOP_V    = HW'(LONG_TICKS + REPEAT_TICKS);

    // Prescaler and sample tick
    logic [PW-1:0]            presc_q, presc_d;
    logic                     tick_q, tick_d;

    // Input path
    logic [N_BTN-1:0]         raw_s;
    logic [N_BTN-1:0]         sync1_q, sync2_q;

    // Debounce, edge and hold state
    logic [N_BTN-1:0]         level_q, level_d;
    logic [N_BTN-1:0]         prev_q;
    logic [N_BTN-1:0]         pedge_q, pedge_d;
    logic [N_BTN-1:0]         nedge_q, nedge_d;
    logic [N_BTN-1:0]         long_q, long_d;
    logic [N_BTN-1:0]         rep_q, rep_d;
    logic [N_BTN-1:0][SW-1:0] stab_q, stab_d;
    logic [N_BTN-1:0][HW-1:0] hold_q, hold_d;
    logic [HW-1:0]            hold_inc_s [N_BTN];

    // Normalise pin polarity so that 1 always means pressed.
    assign raw_s = ACTIVE_LOW ? ~btn : btn;

    // Free-running prescaler; the tick register is high while the count is at its last value.
    always_comb begin
        if (presc_q == DIV_LAST) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PW'(1);
        end
        tick_d = (presc_q == DIV_PRE);
    end

    // Per-channel debounce filter, hold counter, long/repeat and edge pulse generation.
    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            level_d[i]    = level_q[i];
            stab_d[i]     = stab_q[i];
            hold_d[i]     = hold_q[i];
            long_d[i]     = 1'b0;
            rep_d[i]      = 1'b0;
            hold_inc_s[i] = hold_q[i] + HW'(1);

            // Stability filter: a matching sample discards any progress toward a toggle.
            if (tick_q) begin
                if (sync2_q[i] == level_q[i]) begin
                    stab_d[i] = '0;
                end else if ((stab_q[i] + SW'(1)) == STABLE_V) begin
                    level_d[i] = ~level_q[i];
                    stab_d[i]  = '0;
                end else begin
                    stab_d[i] = stab_q[i] + SW'(1);
                end
            end else begin
                stab_d[i] = stab_q[i];
            end

            // Hold counter runs only while the press is established and not being released
            // on this tick, so no long/repeat pulse can follow an accepted release.
            if (!level_q[i] || !level_d[i]) begin
                hold_d[i] = '0;
            end else if (tick_q) begin
                if (hold_q[i] == TOP_V) begin
                    // Only reachable with repeat disabled: saturate at the long-press count.
                    hold_d[i] = hold_q[i];
                end else if ((REPEAT_TICKS != 0) && (hold_inc_s[i] == TOP_V)) begin
                    rep_d[i]  = 1'b1;
                    hold_d[i] = LONG_V;
                end else begin
                    hold_d[i] = hold_inc_s[i];
                    long_d[i] = (hold_inc_s[i] == LONG_V);
                end
            end else begin
                hold_d[i] = hold_q[i];
            end
        end

        // Edge pulses trail the level change by one clock.
        pedge_d = level_q & ~prev_q;
        nedge_d = ~level_q & prev_q;
    end

    // State and output registers; reset forces every output low immediately.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            prev_q  <= '0;
            pedge_q <= '0;
            nedge_q <= '0;
            long_q  <= '0;
            rep_q   <= '0;
            stab_q  <= '0;
            hold_q  <= '0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
            sync1_q <= raw_s;
            sync2_q <= sync1_q;
            level_q <= level_d;
            prev_q  <= level_q;
            pedge_q <= pedge_d;
            nedge_q <= nedge_d;
            long_q  <= long_d;
            rep_q   <= rep_d;
            stab_q  <= stab_d;
            hold_q  <= hold_d;
        end
    end

    assign btn_level   = level_q;
    assign btn_pedge   = pedge_q;
    assign btn_nedge   = nedge_q;
    assign btn_long    = long_q;
    assign btn_rep     = rep_q;
    assign sample_tick = tick_q;

endmodule

// File: tb/tb_button_cntr_multi.sv
// Bench for button_cntr_multi: a phase table, hand-written corner sequences and
// randomized pin activity checked every clock against a behavioural model.
// Two instances run side by side: one with auto-repeat and one with repeat disabled.
module tb_button_cntr_multi;

    localparam int DIV  = 4;
    localparam int STAB = 3;
    localparam int LONG = 5;
    localparam int REP  = 2;

    logic       clk     = 1'b0;
    logic       reset_p = 1'b0;
    logic [1:0] btn     = 2'b00;

    logic [1:0] lvl, ped, ned, lng, rep;
    logic       tick;
    logic [1:0] lvl_nr, ped_nr, ned_nr, lng_nr, rep_nr;
    logic       tick_nr;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    button_cntr_multi #(
        .N_BTN(2), .SAMPLE_DIV(DIV), .STABLE_CNT(STAB),
        .LONG_TICKS(LONG), .REPEAT_TICKS(REP), .ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .reset_p(reset_p), .btn(btn),
        .btn_level(lvl), .btn_pedge(ped), .btn_nedge(ned),
        .btn_long(lng), .btn_rep(rep), .sample_tick(tick)
    );

    button_cntr_multi #(
        .N_BTN(2), .SAMPLE_DIV(DIV), .STABLE_CNT(STAB),
        .LONG_TICKS(LONG), .REPEAT_TICKS(0), .ACTIVE_LOW(1'b0)
    ) dut_nr (
        .clk(clk), .reset_p(reset_p), .btn(btn),
        .btn_level(lvl_nr), .btn_pedge(ped_nr), .btn_nedge(ned_nr),
        .btn_long(lng_nr), .btn_rep(rep_nr), .sample_tick(tick_nr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Tracks edges since reset, the pin value seen two clocks ago, how many consecutive
    // mismatching samples have been seen, and how many sample ticks a press has lasted.
    int         m_edge = 0;
    logic [1:0] m_s1 = 2'b00, m_s2 = 2'b00;
    logic [1:0] m_lvl = 2'b00, m_prev = 2'b00;
    logic [1:0] x_ped = 2'b00, x_ned = 2'b00, x_long = 2'b00, x_rep = 2'b00;
    logic       m_tick = 1'b0;
    int         run [2];
    int         age [2];
    logic [1:0] lvl_old;
    logic       tick_now;

    // Model update on every clock edge, cleared by reset at once.
    always @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            m_edge = 0; m_s1 = 2'b00; m_s2 = 2'b00; m_lvl = 2'b00; m_prev = 2'b00;
            x_ped = 2'b00; x_ned = 2'b00; x_long = 2'b00; x_rep = 2'b00; m_tick = 1'b0;
            for (int c = 0; c < 2; c++) begin run[c] = 0; age[c] = 0; end
        end else begin
            tick_now = m_tick;
            lvl_old  = m_lvl;
            x_ped    = lvl_old & ~m_prev;
            x_ned    = ~lvl_old & m_prev;
            m_prev   = lvl_old;
            x_long   = 2'b00;
            x_rep    = 2'b00;
            if (tick_now) begin
                for (int c = 0; c < 2; c++) begin
                    if (m_s2[c] != lvl_old[c]) run[c] = run[c] + 1;
                    else run[c] = 0;
                    if (run[c] == STAB) begin
                        m_lvl[c] = ~lvl_old[c];
                        run[c]   = 0;
                    end
                    if (lvl_old[c] && m_lvl[c]) begin
                        age[c] = age[c] + 1;
                        if (age[c] == LONG) x_long[c] = 1'b1;
                        if (age[c] > LONG && ((age[c] - LONG) % REP) == 0) x_rep[c] = 1'b1;
                    end else begin
                        age[c] = 0;
                    end
                end
            end
            m_s2   = m_s1;
            m_s1   = btn;
            m_edge = m_edge + 1;
            m_tick = ((m_edge % DIV) == (DIV - 1));
        end
    end

    // Compare both instances with the model in the middle of every clock period.
    always @(negedge clk) begin
        check("model main", 32'({lvl, ped, ned, lng, rep, tick}),
              32'({m_lvl, x_ped, x_ned, x_long, x_rep, m_tick}));
        check("model norep", 32'({lvl_nr, ped_nr, ned_nr, lng_nr, rep_nr, tick_nr}),
              32'({m_lvl, x_ped, x_ned, x_long, 2'b00, m_tick}));
    end

    // ---------------- directed phases ----------------
    typedef struct {
        logic [1:0] btn;
        int         cycles;
        logic [1:0] lvl;
        int         ped0, ned0, long0, rep0, long_nr;
    } phase_t;

    phase_t tbl [5];

    int c_ped, c_ned, c_long, c_rep, c_long_nr, c_rep_nr, c_ch1;
    int cnt, late_rep;
    bit found, seen_ned;

    initial begin
        tbl[0] = '{2'b00,  8, 2'b00, 0, 0, 0, 0, 0};   // idle after reset
        tbl[1] = '{2'b01,  8, 2'b00, 0, 0, 0, 0, 0};   // two-sample glitch
        tbl[2] = '{2'b00, 12, 2'b00, 0, 0, 0, 0, 0};   // glitch rejected
        tbl[3] = '{2'b01, 58, 2'b01, 1, 0, 1, 3, 1};   // press, long, three repeats
        tbl[4] = '{2'b00, 26, 2'b00, 0, 1, 0, 1, 0};   // release, one repeat before it lands

        // Reset with both pins pressed: everything stays low.
        #1 reset_p = 1'b1;
        btn = 2'b11;
        repeat (3) @(negedge clk);
        check("reset outputs", 32'({lvl, ped, ned, lng, rep, tick}), 32'd0);
        check("reset outputs norep", 32'({lvl_nr, ped_nr, ned_nr, lng_nr, rep_nr, tick_nr}), 32'd0);
        reset_p = 1'b0;

        for (int i = 0; i < 5; i++) begin
            btn = tbl[i].btn;
            c_ped = 0; c_ned = 0; c_long = 0; c_rep = 0; c_long_nr = 0; c_rep_nr = 0; c_ch1 = 0;
            repeat (tbl[i].cycles) begin
                @(posedge clk);
                @(negedge clk);
                c_ped     += int'(ped[0]);
                c_ned     += int'(ned[0]);
                c_long    += int'(lng[0]);
                c_rep     += int'(rep[0]);
                c_long_nr += int'(lng_nr[0]);
                c_rep_nr  += int'(rep_nr[0]);
                c_ch1     += int'(lvl[1]) + int'(ped[1]) + int'(ned[1]) + int'(lng[1]) + int'(rep[1]);
            end
            check($sformatf("phase%0d level", i), 32'(lvl), 32'(tbl[i].lvl));
            check($sformatf("phase%0d pedge", i), c_ped, tbl[i].ped0);
            check($sformatf("phase%0d nedge", i), c_ned, tbl[i].ned0);
            check($sformatf("phase%0d long", i), c_long, tbl[i].long0);
            check($sformatf("phase%0d rep", i), c_rep, tbl[i].rep0);
            check($sformatf("phase%0d long norep", i), c_long_nr, tbl[i].long_nr);
            check($sformatf("phase%0d rep norep", i), c_rep_nr, 0);
            check($sformatf("phase%0d ch1 quiet", i), c_ch1, 0);
        end

        // Long hold of 27 ticks: repeat build repeats, non-repeat build fires long once.
        btn = 2'b01;
        c_long = 0; c_rep = 0; c_long_nr = 0; c_rep_nr = 0;
        repeat (120) begin
            @(posedge clk);
            @(negedge clk);
            c_long    += int'(lng[0]);
            c_rep     += int'(rep[0]);
            c_long_nr += int'(lng_nr[0]);
            c_rep_nr  += int'(rep_nr[0]);
        end
        check("hold long", c_long, 1);
        check("hold rep", c_rep, 11);
        check("hold long norep", c_long_nr, 1);
        check("hold rep norep", c_rep_nr, 0);

        // Release: exactly one nedge and nothing repeating afterwards.
        btn = 2'b00;
        c_ned = 0; c_rep = 0; late_rep = 0; seen_ned = 1'b0;
        repeat (30) begin
            @(posedge clk);
            @(negedge clk);
            if (ned[0]) seen_ned = 1'b1;
            if (seen_ned && rep[0]) late_rep++;
            c_ned += int'(ned[0]);
            c_rep += int'(rep[0]);
        end
        check("release nedge", c_ned, 1);
        check("release rep before nedge", c_rep, 1);
        check("release rep after nedge", late_rep, 0);

        // Both channels pressed in the same clock.
        btn = 2'b11;
        found = 1'b0; cnt = 0;
        while (!found && cnt < 40) begin
            @(posedge clk);
            @(negedge clk);
            cnt++;
            if (ped != 2'b00) found = 1'b1;
        end
        check("dual pedge seen", 32'(found), 32'd1);
        check("dual pedge same cycle", 32'(ped), 32'h3);
        repeat (20) @(negedge clk);
        check("dual level held", 32'(lvl), 32'h3);

        // Reset mid-hold drops outputs asynchronously.
        #2 reset_p = 1'b1;
        #1;
        check("midhold reset outputs", 32'({lvl, ped, ned, lng, rep, tick}), 32'd0);
        check("midhold reset outputs norep", 32'({lvl_nr, ped_nr, ned_nr, lng_nr, rep_nr, tick_nr}), 32'd0);
        repeat (3) @(negedge clk);
        reset_p = 1'b0;

        // Still held after reset: fresh press 2 sync clocks plus 3 samples later.
        found = 1'b0; cnt = 0;
        while (!found && cnt < 40) begin
            @(posedge clk);
            @(negedge clk);
            cnt++;
            if (ped != 2'b00) found = 1'b1;
        end
        check("reaccept pedge seen", 32'(found), 32'd1);
        check("reaccept pedge cycle", cnt, 13);
        check("reaccept pedge both", 32'(ped), 32'h3);

        // Randomized pin activity with occasional resets; the model checks every clock.
        for (int s = 0; s < 250; s++) begin
            btn = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) cnt = $urandom_range(40, 150);
            else cnt = $urandom_range(1, 20);
            repeat (cnt) @(negedge clk);
            if ($urandom_range(0, 59) == 0) begin
                #2 reset_p = 1'b1;
                @(negedge clk);
                @(negedge clk);
                reset_p = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Safety net in case any wait above never returns.
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
